// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle for pipe_stage_skid: upstream valid/ready/data, downstream
// valid/ready/data, flush/stat controls and occupancy/stall status.
// Ports: master drives InValid/InData/OutReady/Flush/ClrStats; slave drives the rest.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 128,
    parameter int CNT_W  = 16
);
    logic              InValid;
    logic              InReady;
    logic [DATA_W-1:0] InData;
    logic              OutValid;
    logic              OutReady;
    logic [DATA_W-1:0] OutData;
    logic              Flush;
    logic              ClrStats;
    logic [1:0]        Occupancy;
    logic [CNT_W-1:0]  StallCount;

    modport master (
        output InValid, InData, OutReady, Flush, ClrStats,
        input  InReady, OutValid, OutData, Occupancy, StallCount
    );

    modport slave (
        input  InValid, InData, OutReady, Flush, ClrStats,
        output InReady, OutValid, OutData, Occupancy, StallCount
    );
endinterface

// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with 2-entry skid buffer, flush,
// bubble zeroing and saturating stall counter.
// Ports: Clk, Reset (async active-low), bus (pipe_stage_skid_if.slave).
module pipe_stage_skid #(
    parameter int DATA_W      = 128,
    parameter int ZERO_BUBBLE = 1,
    parameter int CNT_W       = 16
) (
    input  logic                Clk,
    input  logic                Reset,
    pipe_stage_skid_if.slave    bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] main_d;
    logic [DATA_W-1:0] skid_q;
    logic [DATA_W-1:0] skid_d;
    logic              rdy_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_valid;
    logic              acc;
    logic              drn;
    logic              stall;

    assign out_valid = (state != EMPTY);
    assign acc       = bus.InValid & rdy_q;
    assign drn       = out_valid & bus.OutReady;
    assign stall     = out_valid & ~bus.OutReady;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
            rdy_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            state  <= state_nxt;
            main_q <= main_d;
            skid_q <= skid_d;
            // Registered ready: low only when the stage will be full.
            rdy_q  <= (state_nxt != FULL);
            if (bus.ClrStats)
                cnt_q <= '0;
            else if (stall && (cnt_q != '1))
                cnt_q <= cnt_q + 1'b1;
        end
    end

    // InData is only captured on acc, so X on an idle bus never lands in state.
    always_comb begin
        state_nxt = state;
        main_d    = main_q;
        skid_d    = skid_q;
        if (bus.Flush) begin
            // A same-cycle acc is dropped; a same-cycle drn has already been seen.
            state_nxt = EMPTY;
            skid_d    = '0;
            if (ZERO_BUBBLE != 0)
                main_d = '0;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (acc) begin
                        state_nxt = ONE;
                        main_d    = bus.InData;
                    end
                end
                ONE: begin
                    unique case (1'b1)
                        acc && drn: main_d = bus.InData;
                        acc && !drn: begin
                            state_nxt = FULL;
                            skid_d    = bus.InData;
                        end
                        !acc && drn: state_nxt = EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (drn) begin
                        state_nxt = ONE;
                        main_d    = skid_q;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.InReady    = rdy_q;
        bus.OutValid   = out_valid;
        bus.StallCount = cnt_q;
        bus.OutData    = main_q;
        if ((ZERO_BUBBLE != 0) && !out_valid)
            bus.OutData = '0;
        unique case (state)
            EMPTY:   bus.Occupancy = 2'd0;
            ONE:     bus.Occupancy = 2'd1;
            FULL:    bus.Occupancy = 2'd2;
            default: bus.Occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Testbench for pipe_stage_skid: two instances (bubble-zeroing with 3-bit
// counter, data-holding with 16-bit counter) checked against a queue model.
module tb_pipe_stage_skid;

    localparam int DW = 16;

    logic          clk;
    logic          rst_n;
    logic          iv;
    logic [DW-1:0] idata;
    logic          ordy;
    logic          fl;
    logic          clr;

    pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(3))  ifa ();
    pipe_stage_skid_if #(.DATA_W(DW), .CNT_W(16)) ifb ();

    assign ifa.InValid  = iv;
    assign ifa.InData   = idata;
    assign ifa.OutReady = ordy;
    assign ifa.Flush    = fl;
    assign ifa.ClrStats = clr;
    assign ifb.InValid  = iv;
    assign ifb.InData   = idata;
    assign ifb.OutReady = ordy;
    assign ifb.Flush    = fl;
    assign ifb.ClrStats = clr;

    pipe_stage_skid #(.DATA_W(DW), .ZERO_BUBBLE(1), .CNT_W(3)) u_a (
        .Clk(clk), .Reset(rst_n), .bus(ifa)
    );
    pipe_stage_skid #(.DATA_W(DW), .ZERO_BUBBLE(0), .CNT_W(16)) u_b (
        .Clk(clk), .Reset(rst_n), .bus(ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO of held payloads, registered ready, counters.
    logic [DW-1:0] q[$];
    logic [DW-1:0] last_head;
    logic          m_rdy;
    int unsigned   ca;
    int unsigned   cb;
    int            n_chk;
    int            n_pass;

    function automatic logic [DW-1:0] exp_a();
        return (q.size() != 0) ? q[0] : '0;
    endfunction

    function automatic logic [DW-1:0] exp_b();
        return (q.size() != 0) ? q[0] : last_head;
    endfunction

    task automatic model_reset();
        q.delete();
        last_head = '0;
        m_rdy     = 1'b0;
        ca        = 0;
        cb        = 0;
    endtask

    // One clock edge: update the model from the inputs applied before it.
    task automatic step();
        bit acc;
        bit drn;
        @(posedge clk);
        acc = iv && m_rdy;
        drn = (q.size() != 0) && ordy;
        if (clr) begin
            ca = 0;
            cb = 0;
        end else if ((q.size() != 0) && !ordy) begin
            if (ca != 7)     ca++;
            if (cb != 65535) cb++;
        end
        if (fl) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(idata);
        end
        if (q.size() != 0) last_head = q[0];
        m_rdy = (q.size() < 2);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iv = 1'b1; idata = 16'h0099;
        ordy = 1'b1; fl = 1'b0; clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (ifa.InReady !== 1'b0) $display("FAIL rst_inready got=%b exp=0", ifa.InReady); else n_pass++;
        n_chk++; if (ifa.OutValid !== 1'b0) $display("FAIL rst_outvalid got=%b exp=0", ifa.OutValid); else n_pass++;
        n_chk++; if (ifa.OutData !== '0) $display("FAIL rst_outdata got=%h exp=0", ifa.OutData); else n_pass++;
        n_chk++; if (ifb.OutData !== '0) $display("FAIL rst_outdata_b got=%h exp=0", ifb.OutData); else n_pass++;
        n_chk++; if (ifa.Occupancy !== 2'd0) $display("FAIL rst_occ got=%0d exp=0", ifa.Occupancy); else n_pass++;
        n_chk++; if (ifa.StallCount !== 3'd0) $display("FAIL rst_stall got=%0d exp=0", ifa.StallCount); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_chk++; if (ifa.InReady !== 1'b0) $display("FAIL rel_inready_pre got=%b exp=0", ifa.InReady); else n_pass++;
        step();
        n_chk++; if (ifa.InReady !== 1'b1) $display("FAIL rel_inready_post got=%b exp=1", ifa.InReady); else n_pass++;
        n_chk++; if (ifa.OutValid !== 1'b0) $display("FAIL rel_no_xfer got=%b exp=0", ifa.OutValid); else n_pass++;
        iv = 1'b0;
    endtask

    task automatic test_streaming();
        iv = 1'b1; ordy = 1'b1; clr = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            idata = DW'(k);
            step();
            clr = 1'b0;
            n_chk++; if (ifa.OutData !== DW'(k)) $display("FAIL stream_data got=%h exp=%h", ifa.OutData, DW'(k)); else n_pass++;
            n_chk++; if (ifa.Occupancy !== 2'd1) $display("FAIL stream_occ got=%0d exp=1", ifa.Occupancy); else n_pass++;
            n_chk++; if (ifa.InReady !== 1'b1) $display("FAIL stream_rdy got=%b exp=1", ifa.InReady); else n_pass++;
            n_chk++; if (ifb.StallCount !== 16'd0) $display("FAIL stream_stall got=%0d exp=0", ifb.StallCount); else n_pass++;
        end
        iv = 1'b0;
        step();
        n_chk++; if (ifa.Occupancy !== 2'd0) $display("FAIL stream_drain_occ got=%0d exp=0", ifa.Occupancy); else n_pass++;
    endtask

    task automatic test_backpressure();
        ordy = 1'b0; iv = 1'b1; idata = 16'h000A; clr = 1'b1;
        step();
        clr = 1'b0;
        n_chk++; if (ifa.Occupancy !== 2'd1) $display("FAIL bp_occ1 got=%0d exp=1", ifa.Occupancy); else n_pass++;
        idata = 16'h000B;
        step();
        n_chk++; if (ifa.Occupancy !== 2'd2) $display("FAIL bp_occ2 got=%0d exp=2", ifa.Occupancy); else n_pass++;
        n_chk++; if (ifa.InReady !== 1'b0) $display("FAIL bp_rdy_low got=%b exp=0", ifa.InReady); else n_pass++;
        n_chk++; if (ifa.OutData !== 16'h000A) $display("FAIL bp_head got=%h exp=000a", ifa.OutData); else n_pass++;
        iv = 1'b0; idata = 'x;
        step();
        ordy = 1'b1;
        step();
        n_chk++; if (ifa.OutData !== 16'h000B) $display("FAIL bp_second got=%h exp=000b", ifa.OutData); else n_pass++;
        n_chk++; if (ifa.InReady !== 1'b1) $display("FAIL bp_rdy_back got=%b exp=1", ifa.InReady); else n_pass++;
        n_chk++; if (ifb.StallCount !== 16'd2) $display("FAIL bp_stall got=%0d exp=2", ifb.StallCount); else n_pass++;
        step();
        n_chk++; if (ifa.Occupancy !== 2'd0) $display("FAIL bp_empty got=%0d exp=0", ifa.Occupancy); else n_pass++;
    endtask

    task automatic test_flush_full();
        ordy = 1'b0; iv = 1'b1; idata = 16'h0005;
        step();
        idata = 16'h0006;
        step();
        n_chk++; if (ifa.Occupancy !== 2'd2) $display("FAIL fl_full got=%0d exp=2", ifa.Occupancy); else n_pass++;
        fl = 1'b1; idata = 16'h0007;
        step();
        fl = 1'b0; iv = 1'b0;
        n_chk++; if (ifa.OutValid !== 1'b0) $display("FAIL fl_valid got=%b exp=0", ifa.OutValid); else n_pass++;
        n_chk++; if (ifa.OutData !== '0) $display("FAIL fl_bubble got=%h exp=0", ifa.OutData); else n_pass++;
        n_chk++; if (ifa.Occupancy !== 2'd0) $display("FAIL fl_occ got=%0d exp=0", ifa.Occupancy); else n_pass++;
        n_chk++; if (ifa.InReady !== 1'b1) $display("FAIL fl_rdy got=%b exp=1", ifa.InReady); else n_pass++;
        n_chk++; if (ifb.OutData !== 16'h0005) $display("FAIL fl_hold_b got=%h exp=0005", ifb.OutData); else n_pass++;
        ordy = 1'b1;
        repeat (2) begin
            step();
            n_chk++; if (ifa.OutValid !== 1'b0) $display("FAIL fl_no_7 got=%b exp=0", ifa.OutValid); else n_pass++;
        end
    endtask

    task automatic test_saturation();
        ordy = 1'b0; iv = 1'b1; idata = 16'h0011; clr = 1'b1;
        step();
        clr = 1'b0; iv = 1'b0;
        repeat (10) step();
        n_chk++; if (ifa.StallCount !== 3'd7) $display("FAIL sat_a got=%0d exp=7", ifa.StallCount); else n_pass++;
        n_chk++; if (ifb.StallCount !== 16'd10) $display("FAIL sat_b got=%0d exp=10", ifb.StallCount); else n_pass++;
        clr = 1'b1;
        step();
        clr = 1'b0;
        n_chk++; if (ifa.StallCount !== 3'd0) $display("FAIL clr_prio got=%0d exp=0", ifa.StallCount); else n_pass++;
        step();
        n_chk++; if (ifa.StallCount !== 3'd1) $display("FAIL clr_resume got=%0d exp=1", ifa.StallCount); else n_pass++;
        ordy = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        ordy = 1'b0; iv = 1'b1; idata = 16'h00C1;
        step();
        idata = 16'h00C2;
        step();
        iv = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_chk++; if (ifa.OutValid !== 1'b0) $display("FAIL ar_valid got=%b exp=0", ifa.OutValid); else n_pass++;
        n_chk++; if (ifa.InReady !== 1'b0) $display("FAIL ar_rdy got=%b exp=0", ifa.InReady); else n_pass++;
        n_chk++; if (ifa.Occupancy !== 2'd0) $display("FAIL ar_occ got=%0d exp=0", ifa.Occupancy); else n_pass++;
        n_chk++; if (ifb.OutData !== '0) $display("FAIL ar_data got=%h exp=0", ifb.OutData); else n_pass++;
        n_chk++; if (ifb.StallCount !== 16'd0) $display("FAIL ar_stall got=%0d exp=0", ifb.StallCount); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_chk++; if (ifa.InReady !== 1'b1) $display("FAIL ar_rel_rdy got=%b exp=1", ifa.InReady); else n_pass++;
    endtask

    task automatic test_no_bubble();
        ordy = 1'b1; iv = 1'b1; idata = 16'h003C;
        step();
        iv = 1'b0; idata = 'x;
        step();
        n_chk++; if (ifb.OutValid !== 1'b0) $display("FAIL nb_valid got=%b exp=0", ifb.OutValid); else n_pass++;
        n_chk++; if (ifb.OutData !== 16'h003C) $display("FAIL nb_hold got=%h exp=003c", ifb.OutData); else n_pass++;
        n_chk++; if (ifa.OutData !== '0) $display("FAIL zb_zero got=%h exp=0", ifa.OutData); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            iv    = ($urandom_range(0, 3) != 0);
            idata = iv ? DW'($urandom) : 'x;
            ordy  = ($urandom_range(0, 3) != 0);
            fl    = ($urandom_range(0, 19) == 0);
            clr   = ($urandom_range(0, 19) == 0);
            step();
            n_chk++; if (ifa.OutValid !== (q.size() != 0)) $display("FAIL rnd_valid i=%0d got=%b exp=%b", i, ifa.OutValid, q.size() != 0); else n_pass++;
            n_chk++; if (ifa.InReady !== m_rdy) $display("FAIL rnd_rdy i=%0d got=%b exp=%b", i, ifa.InReady, m_rdy); else n_pass++;
            n_chk++; if (ifa.Occupancy !== 2'(q.size())) $display("FAIL rnd_occ i=%0d got=%0d exp=%0d", i, ifa.Occupancy, q.size()); else n_pass++;
            n_chk++; if (ifa.OutData !== exp_a()) $display("FAIL rnd_data_a i=%0d got=%h exp=%h", i, ifa.OutData, exp_a()); else n_pass++;
            n_chk++; if (ifb.OutData !== exp_b()) $display("FAIL rnd_data_b i=%0d got=%h exp=%h", i, ifb.OutData, exp_b()); else n_pass++;
            n_chk++; if (ifa.StallCount !== 3'(ca)) $display("FAIL rnd_stall_a i=%0d got=%0d exp=%0d", i, ifa.StallCount, ca); else n_pass++;
            n_chk++; if (ifb.StallCount !== 16'(cb)) $display("FAIL rnd_stall_b i=%0d got=%0d exp=%0d", i, ifb.StallCount, cb); else n_pass++;
        end
        fl = 1'b0; clr = 1'b0; iv = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush_full();
        test_saturation();
        test_async_reset();
        test_no_bubble();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, handshaked pipeline stage register. Successor to the fixed-field stage registers between Decode/Execute/Memory/Writeback.
- Carries an opaque payload of DATA_W bits (control + data fields concatenated by the instantiating stage).
- Adds valid/ready flow control with a 2-entry skid buffer, synchronous flush (branch/jump squash), a bubble-zeroing mode and a saturating stall counter.
- Sustains 1 transfer/cycle with a fully registered InReady.

Parameters:
- DATA_W, 128, payload width in bits (>=1).
- ZERO_BUBBLE, 1, 1: OutData forced to 0 whenever OutValid=0; 0: OutData holds the last main-entry value.
- CNT_W, 16, StallCount width (>=1).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- InValid  input  1  upstream has a payload.
- InReady  output  1  stage can accept; registered.
- InData  input  DATA_W  upstream payload.
- OutValid  output  1  main entry holds a payload.
- OutReady  input  1  downstream accepts.
- OutData  output  DATA_W  main-entry payload.
- Flush  input  1  synchronous squash of all held entries.
- ClrStats  input  1  synchronous clear of StallCount.
- Occupancy  output  2  entries held: 0, 1 or 2.
- StallCount  output  CNT_W  cycles with OutValid=1 and OutReady=0; saturating.

Behaviour:
- Definitions: acc = InValid & InReady; drn = OutValid & OutReady.
- Storage: main register (drives OutData) and skid register.
- State encoding: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid). Occupancy = 0/1/2 and OutValid = (state != EMPTY); both decoded from the state register.
- Reset asserted (Reset=0), asynchronous:
  - state EMPTY; main, skid, StallCount all 0.
  - InReady=0, OutValid=0, OutData=0.
- After reset release: InReady register loads !(next_state==FULL) at each edge, so InReady first rises at the first rising edge after release. No transfer is possible during reset or in that first cycle.
- Transitions when Flush=0:
  - EMPTY, acc: -> ONE, main<=InData.
  - EMPTY, otherwise: stay EMPTY.
  - ONE, acc & drn: stay ONE, main<=InData.
  - ONE, acc & !drn: -> FULL, skid<=InData.
  - ONE, !acc & drn: -> EMPTY.
  - ONE, otherwise: stay ONE.
  - FULL, drn: -> ONE, main<=skid.
  - FULL, otherwise: stay FULL. acc cannot occur because InReady=0.
- Flush=1 (highest priority below reset):
  - next state EMPTY; skid cleared.
  - main cleared when ZERO_BUBBLE=1, otherwise held.
  - A same-cycle acc is discarded; a same-cycle drn still completes downstream (already presented).
  - InReady is 1 the next cycle.
- Latency: payload accepted at edge N is presented on OutData with OutValid=1 after edge N (cycle N+1).
- Ordering: strict FIFO; skid data never overtakes main.
- Bubble: when ZERO_BUBBLE=1 and OutValid=0, OutData=0 combinationally from registered state, so control bits read as a NOP.
- InData sampled only on acc; X on InData while InValid=0 must not propagate.
- StallCount:
  - increments on every edge with OutValid=1 & OutReady=0; holds at all-ones (saturates).
  - ClrStats=1 loads 0 and takes priority over increment.
  - Flush does not affect it.
- Reset mid-transfer: all entries lost, outputs return to reset values immediately (asynchronous).

Test Plan:
- Reset then streaming: release Reset, InValid=1, OutReady=1, InData=1,2,3,… each cycle -> InReady=1 from the first edge after release; OutData=1,2,3 on consecutive cycles, one cycle after acceptance; Occupancy=1 throughout; StallCount=0.
- Backpressure fill: OutReady=0, offer 0xA then 0xB -> Occupancy 1 then 2, InReady=0 the cycle after 0xB is accepted, OutData=0xA. Raise OutReady -> 0xA then 0xB delivered, InReady=1 the next cycle, Occupancy back to 0. StallCount = number of OutReady=0 cycles with OutValid=1.
- Flush in FULL: FULL with 0x5/0x6, assert Flush with InValid=1, InData=0x7 -> next cycle OutValid=0, OutData=0 (ZERO_BUBBLE=1), Occupancy=0; 0x7 never appears at the output.
- Saturation: CNT_W=3, hold OutValid=1, OutReady=0 for 10 cycles -> StallCount stops at 7. ClrStats together with a stall -> StallCount=0.
- Async reset mid-FULL: drop Reset between clock edges -> OutValid, InReady, Occupancy, OutData go to 0 immediately with no clock edge.
- ZERO_BUBBLE=0: after draining payload 0x3C -> OutValid=0 and OutData holds 0x3C.
